// File: rtl/btb_fetch_unit_pkg.sv
// ============================================================================
// Module : mips_bp_pkg
// Brief  : Shared types, counter encodings and width helpers for the BTB
//          fetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // The low two PC bits are the byte offset within a word.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entries);
    return addr_w - idx_w(entries) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_fetch_unit_if.sv
// ============================================================================
// Module : btb_fetch_unit_if
// Brief  : Fetch-side bus: EX branch feedback, stall input, and the fetch
//          PC / prediction / flush outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btb_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              freeze;
  logic              ex_br_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              flush;

  modport master (
    output freeze, ex_br_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  freeze, ex_br_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target, flush
  );
endinterface

`default_nettype wire

// File: rtl/btb_fetch_unit_table.sv
// ============================================================================
// Module : btb_table
// Brief  : Direct-mapped BTB with 2-bit counters; combinational lookup and a
//          synchronous update port applying allocation/saturation rules.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_table
  import mips_bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = idx_w(ENTRIES),
  localparam int unsigned TAG_W  = tag_w(ADDR_W, ENTRIES)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [IDX_W-1:0]  rd_idx_i,
  input  wire logic [TAG_W-1:0]  rd_tag_i,
  output logic                   rd_taken_o,
  output logic [ADDR_W-1:0]      rd_target_o,
  input  wire logic              wr_en_i,
  input  wire logic [IDX_W-1:0]  wr_idx_i,
  input  wire logic [TAG_W-1:0]  wr_tag_i,
  input  wire logic              wr_taken_i,
  input  wire logic [ADDR_W-1:0] wr_target_i
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    ctr_e              ctr;
  } btb_entry_t;

  btb_entry_t entry_q [ENTRIES];

  btb_entry_t w_rd_e;
  btb_entry_t w_wr_e;
  logic       w_rd_hit;
  logic       w_wr_hit;

  // Lookup reads the registered array, so a same-cycle update is not seen.
  always_comb begin
    w_rd_e      = entry_q[rd_idx_i];
    w_rd_hit    = w_rd_e.valid && (w_rd_e.tag == rd_tag_i);
    rd_taken_o  = w_rd_hit && w_rd_e.ctr[1];
    rd_target_o = rd_taken_o ? w_rd_e.target : '0;
  end

  always_comb begin
    w_wr_e   = entry_q[wr_idx_i];
    w_wr_hit = w_wr_e.valid && (w_wr_e.tag == wr_tag_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (wr_en_i) begin
      if (w_wr_hit) begin
        if (wr_taken_i) begin
          entry_q[wr_idx_i].target <= wr_target_i;
          if (w_wr_e.ctr != ST) entry_q[wr_idx_i].ctr <= ctr_e'(w_wr_e.ctr + 2'd1);
        end else if (w_wr_e.ctr != SNT) begin
          entry_q[wr_idx_i].ctr <= ctr_e'(w_wr_e.ctr - 2'd1);
        end
      end else if (wr_taken_i) begin
        entry_q[wr_idx_i] <= '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i, ctr: WT};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_fetch_unit.sv
// ============================================================================
// Module : btb_fetch_unit
// Brief  : IF-stage PC unit with BTB prediction, EX mispredict recovery and
//          optional branch statistics (enable with `define BTB_STATS_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_fetch_unit
  import mips_bp_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  btb_fetch_unit_if.slave  bus,
  output logic [31:0]      stat_branches_o,
  output logic [31:0]      stat_mispredicts_o
);

  localparam int unsigned IDX_W = idx_w(BTB_ENTRIES);
  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic              w_mispredict;

  btb_table #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (pc_q[IDX_W+1:2]),
    .rd_tag_i    (pc_q[ADDR_W-1:IDX_W+2]),
    .rd_taken_o  (w_pred_taken),
    .rd_target_o (w_pred_target),
    .wr_en_i     (bus.ex_br_valid),
    .wr_idx_i    (bus.ex_pc[IDX_W+1:2]),
    .wr_tag_i    (bus.ex_pc[ADDR_W-1:IDX_W+2]),
    .wr_taken_i  (bus.ex_taken),
    .wr_target_i (bus.ex_target)
  );

  // A correct direction with a wrong target still counts as a mispredict.
  always_comb begin
    w_mispredict = bus.ex_br_valid &&
                   ((bus.ex_taken != bus.ex_pred_taken) ||
                    (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target)));
  end

  always_comb begin
    pc_d = pc_q + C_STEP;
    if (w_mispredict)      pc_d = bus.ex_taken ? bus.ex_target : bus.ex_pc + C_STEP;
    else if (bus.freeze)   pc_d = pc_q;
    else if (w_pred_taken) pc_d = w_pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;
  assign bus.flush       = w_mispredict;

`ifdef BTB_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bus.ex_br_valid && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (w_mispredict && (stat_mp_q != '1))    stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`else
  assign stat_branches_o    = 32'd0;
  assign stat_mispredicts_o = 32'd0;
`endif

endmodule

`default_nettype wire
